uart_rx: RTL
============

Name: uart_rx

Overview:
- 8N1 UART receiver; the downstream stage of uart_tx, consuming its serial tx line.
- Samples the serial line with a per-bit clock counter and reassembles the byte LSB-first.
- Presents each byte with a one-cycle valid strobe and flags framing errors.
- Same clock domain and baud setting as uart_tx; the serial input is treated as asynchronous.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 4 and match uart_tx.
- SYNC_STAGES, 2, synchronizer flops on rx; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous.
- rx_data  output  8  last correctly received byte; held until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- rx_busy  output  1  high while in any state other than IDLE.
- frame_err  output  1  one-cycle pulse when the stop bit samples 0.
- parity_err  output  1  one-cycle parity-error pulse; see Optional Feature.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, counters=0, shift register=0.
  - Synchronizer flops=1.
  - rx_data=8'h00; rx_valid, rx_busy, frame_err and parity_err all 0.
  - Reset mid-frame abandons the frame; no strobes are issued.
- Synchronizer: rx passes through SYNC_STAGES flops; the output is rx_s. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2 (integer division). cnt is a bit-period counter wide enough for CLKS_PER_BIT-1. bidx is 3 bits.
- IDLE:
  - rx_s==0 -> START with cnt=0.
  - Otherwise stay.
- START:
  - cnt increments each cycle.
  - At cnt==HALF-1: rx_s==0 -> DATA with cnt=0, bidx=0.
  - At cnt==HALF-1: rx_s==1 -> IDLE (glitch rejected; no strobe).
- DATA:
  - cnt increments; at cnt==CLKS_PER_BIT-1, shift rx_s in LSB-first (shift <= {rx_s, shift[7:1]}) and clear cnt.
  - After the sample at bidx==7 -> STOP (or PARITY when enabled); otherwise bidx increments.
- STOP:
  - At cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s==1: rx_data<=shift and rx_valid=1 on the next cycle; then -> IDLE.
  - rx_s==0: frame_err=1 for one cycle; rx_data unchanged; -> WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rx_s==1, then -> IDLE.
  - Prevents a break condition (line held low) from retriggering a start.
- Strobe timing:
  - rx_valid and frame_err are registered and last exactly one cycle.
  - They can never assert in the same cycle.
- Latency: rx_valid rises within 9*CLKS_PER_BIT+HALF+SYNC_STAGES+2 clk of the start-bit falling edge at rx.
- Back-to-back frames: the start bit following the stop-bit sample is accepted. IDLE is re-entered mid-stop-bit, so no frame is lost at uart_tx's maximum rate.
- rx_busy is combinational from state: (state != IDLE).

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP; one bit period is sampled at cnt==CLKS_PER_BIT-1.
  - Even parity: expected bit = ^shift.
  - On mismatch, parity_err pulses for one cycle, coincident with the stop-bit decision.
  - On a parity error with a valid stop bit, rx_data is still not updated and rx_valid does not pulse.
  - Latency grows by CLKS_PER_BIT.
- When not defined:
  - No PARITY state exists.
  - parity_err is tied to 0.

Test Plan:
- Loopback uart_tx->uart_rx, CLKS_PER_BIT=16, send 8'hA5 -> exactly one rx_valid pulse with rx_data==8'hA5; frame_err stays 0.
- Send 8'h00 then 8'hFF back-to-back (uart_tx restarted on tx_done) -> two rx_valid pulses carrying 00 then FF, in order.
- Drive rx low for 3 clk, then high -> no rx_valid, no frame_err; rx_busy high at most HALF+SYNC_STAGES cycles; returns to IDLE.
- Bit-bang frame 8'h3C with stop bit=0 and hold rx low for 40 bit times -> one frame_err pulse; rx_data keeps its previous value; no new start until rx returns high; then 8'h5A is received correctly.
- Assert rst (low) during data bit 4 of a frame -> all outputs 0 on the next cycle. A subsequent clean frame 8'hC3 after rx idles high for one bit time is received correctly.
- With UART_RX_PARITY_EN, bit-bang 8'h81 with parity bit=1 (wrong) -> one parity_err pulse, no rx_valid. With parity=0 -> rx_valid pulses with rx_data==8'h81.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side bundle of uart_rx: serial line in, byte/strobe/status out.
// slave is the receiver's view; master is the view of whoever drives rx and consumes bytes.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output rx_busy,
        output frame_err,
        output parity_err
    );

    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  rx_busy,
        input  frame_err,
        input  parity_err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples mid-bit, reassembles LSB-first, flags framing errors.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    uart_rx_if.slave   bus
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                 state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [2:0]             bidx_q,      bidx_d;
    logic [7:0]             shift_q,     shift_d;
    logic [SYNC_STAGES-1:0] sync_q,      sync_d;
    logic [7:0]             rx_data_q,   rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q,    par_bad_d;
    logic                   parity_err_q, parity_err_d;
`endif

    logic             rx_s;
    logic             cnt_last;
    logic [CNT_W-1:0] cnt_inc;

    assign rx_s     = sync_q[SYNC_STAGES-1];
    assign cnt_last = (cnt_q == CNT_LAST);
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bidx_d      = bidx_q;
        shift_d     = shift_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], bus.rx};
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end

            // Re-check the line half a bit in; a short low pulse is rejected
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    bidx_d  = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DATA: begin
                if (cnt_last) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = '0;
                    if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_last) begin
                    par_bad_d = rx_s ^ (^shift_q);
                    cnt_d     = '0;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`endif

            // Decision is made mid-stop-bit so a following start edge is not missed
            S_STOP: begin
                if (cnt_last) begin
                    cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = par_bad_q;
`endif
                    if (rx_s) begin
                        state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (!par_bad_q) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end
`else
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            // A held-low line (break) must return high before a new start is accepted
            S_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bidx_q      <= '0;
            shift_q     <= '0;
            sync_q      <= '1;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bidx_q      <= bidx_d;
            shift_q     <= shift_d;
            sync_q      <= sync_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
